// File: rtl/jserial_alu.sv
`default_nettype none
// ============================================================================
// Module   : jserial_alu
// Purpose  : Bit-serial ALU. One full-adder/comparator slice handles one
//            result bit per clock. WIDTH bits finish in WIDTH cycles.
// Options  : JSERIAL_ALU_ABORT_EN adds the wabort input, which cancels a run.
// Revision : 1.0 - initial release
// ============================================================================
module jserial_alu #(
  parameter int WIDTH = 8,
  parameter int CW    = $clog2(WIDTH + 1)
) (
  input  logic             wclk,
  input  logic             wreset,
  input  logic             wstart,
  input  logic [2:0]       wop,
  input  logic [WIDTH-1:0] wa,
  input  logic [WIDTH-1:0] wb,
  input  logic             wci,
`ifdef JSERIAL_ALU_ABORT_EN
  input  logic             wabort,
`endif
  output logic             wbusy,
  output logic             wdone,
  output logic [WIDTH-1:0] wc,
  output logic             wco,
  output logic             weqo,
  output logic             walo,
  output logic             wz
);

  localparam logic [2:0] c_OP_ADD = 3'b000;
  localparam logic [2:0] c_OP_SHR = 3'b001;
  localparam logic [2:0] c_OP_SHL = 3'b010;
  localparam logic [2:0] c_OP_NOT = 3'b011;
  localparam logic [2:0] c_OP_AND = 3'b100;
  localparam logic [2:0] c_OP_OR  = 3'b101;
  localparam logic [2:0] c_OP_XOR = 3'b110;
  localparam logic [2:0] c_OP_CMP = 3'b111;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t           r_state;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-1:0] r_res;
  logic [2:0]       r_op;
  logic             r_c;
  logic             r_eq;
  logic             r_alo;
  logic [CW-1:0]    r_cnt;

  logic             w_msb_first;
  logic             w_abit;
  logic             w_bbit;
  logic             w_rbit;
  logic             w_c_next;
  logic             w_eq_next;
  logic             w_alo_next;
  logic             w_co_final;
  logic             w_last;
  logic             w_abort;
  logic [WIDTH-1:0] w_res_next;

`ifdef JSERIAL_ALU_ABORT_EN
  assign w_abort = wabort;
`else
  assign w_abort = 1'b0;
`endif

  // SHR and CMP walk the operands from the MSB down; everything else LSB up.
  assign w_msb_first = (r_op == c_OP_SHR) || (r_op == c_OP_CMP);
  assign w_abit      = w_msb_first ? r_a[WIDTH-1] : r_a[0];
  assign w_bbit      = w_msb_first ? r_b[WIDTH-1] : r_b[0];
  assign w_last      = (r_cnt == CW'(WIDTH - 1));

  // Result bits enter at the end opposite to the walk direction, so that after
  // WIDTH shifts every bit sits at its own index.
  assign w_res_next  = w_msb_first ? {r_res[WIDTH-2:0], w_rbit}
                                   : {w_rbit, r_res[WIDTH-1:1]};

  // Single bit-slice: result bit plus the next carry / compare flags.
  always_comb begin
    w_rbit     = 1'b0;
    w_c_next   = r_c;
    w_eq_next  = r_eq;
    w_alo_next = r_alo;
    w_co_final = 1'b0;
    case (r_op)
      c_OP_ADD: begin
        w_rbit     = w_abit ^ w_bbit ^ r_c;
        w_c_next   = (w_abit & w_bbit) | (r_c & (w_abit ^ w_bbit));
        w_co_final = w_c_next;
      end
      c_OP_SHR, c_OP_SHL: begin
        // Emit the held bit, then hold the current operand bit.
        w_rbit     = r_c;
        w_c_next   = w_abit;
        w_co_final = w_c_next;
      end
      c_OP_NOT: w_rbit = ~w_abit;
      c_OP_AND: w_rbit = w_abit & w_bbit;
      c_OP_OR:  w_rbit = w_abit | w_bbit;
      c_OP_XOR: w_rbit = w_abit ^ w_bbit;
      c_OP_CMP: begin
        // The first differing bit from the top decides the ordering.
        w_rbit     = w_abit ^ w_bbit;
        w_alo_next = r_alo | (r_eq & w_abit & ~w_bbit);
        w_eq_next  = r_eq & ~(w_abit ^ w_bbit);
      end
      default: ;
    endcase
  end

  // Control FSM, operand shift registers and registered outputs.
  always_ff @(posedge wclk or posedge wreset) begin
    if (wreset) begin
      r_state <= S_IDLE;
      r_a     <= '0;
      r_b     <= '0;
      r_res   <= '0;
      r_op    <= '0;
      r_c     <= 1'b0;
      r_eq    <= 1'b0;
      r_alo   <= 1'b0;
      r_cnt   <= '0;
      wbusy   <= 1'b0;
      wdone   <= 1'b0;
      wc      <= '0;
      wco     <= 1'b0;
      weqo    <= 1'b0;
      walo    <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE, S_DONE: begin
          wdone <= 1'b0;
          if (wstart) begin
            r_a     <= wa;
            r_b     <= wb;
            r_op    <= wop;
            r_c     <= wci;
            r_eq    <= 1'b1;
            r_alo   <= 1'b0;
            r_res   <= '0;
            r_cnt   <= '0;
            wbusy   <= 1'b1;
            r_state <= S_RUN;
          end else begin
            r_state <= S_IDLE;
          end
        end
        S_RUN: begin
          if (w_abort) begin
            wbusy   <= 1'b0;
            r_state <= S_IDLE;
          end else begin
            r_a   <= w_msb_first ? (r_a << 1) : (r_a >> 1);
            r_b   <= w_msb_first ? (r_b << 1) : (r_b >> 1);
            r_res <= w_res_next;
            r_c   <= w_c_next;
            r_eq  <= w_eq_next;
            r_alo <= w_alo_next;
            r_cnt <= r_cnt + 1'b1;
            if (w_last) begin
              wc      <= w_res_next;
              wco     <= w_co_final;
              weqo    <= (r_op == c_OP_CMP) ? w_eq_next  : 1'b0;
              walo    <= (r_op == c_OP_CMP) ? w_alo_next : 1'b0;
              wbusy   <= 1'b0;
              wdone   <= 1'b1;
              r_state <= S_DONE;
            end
          end
        end
        default: begin
          wbusy   <= 1'b0;
          wdone   <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign wz = (wc == '0);

endmodule
`default_nettype wire

// File: tb/tb_jserial_alu.sv
`default_nettype none
// ============================================================================
// Module   : tb_jserial_alu
// Purpose  : Self-checking bench for jserial_alu (WIDTH=8): directed vector
//            table, reset/abort/ignored-start sequences, random vs. model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_jserial_alu;
  localparam int W = 8;

  logic         wclk = 1'b0;
  logic         wreset;
  logic         wstart;
  logic [2:0]   wop;
  logic [W-1:0] wa;
  logic [W-1:0] wb;
  logic         wci;
`ifdef JSERIAL_ALU_ABORT_EN
  logic         wabort;
`endif
  logic         wbusy;
  logic         wdone;
  logic [W-1:0] wc;
  logic         wco;
  logic         weqo;
  logic         walo;
  logic         wz;

  int n_checks = 0;
  int n_errors = 0;

  jserial_alu #(.WIDTH(W)) dut (
    .wclk   (wclk),
    .wreset (wreset),
    .wstart (wstart),
    .wop    (wop),
    .wa     (wa),
    .wb     (wb),
    .wci    (wci),
`ifdef JSERIAL_ALU_ABORT_EN
    .wabort (wabort),
`endif
    .wbusy  (wbusy),
    .wdone  (wdone),
    .wc     (wc),
    .wco    (wco),
    .weqo   (weqo),
    .walo   (walo),
    .wz     (wz)
  );

  always #5 wclk = ~wclk;

  typedef struct {
    logic [2:0]   op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         ci;
    logic         b2b;
    logic [W-1:0] c;
    logic         co;
    logic         eq;
    logic         alo;
    logic         z;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Reference: whole-word arithmetic straight from the op-code definitions.
  function automatic logic [W+2:0] model(input logic [2:0] op, input logic [W-1:0] a,
                                         input logic [W-1:0] b, input logic ci);
    logic [W:0]   s;
    logic [W-1:0] c;
    logic         co, eq, alo;
    co = 1'b0; eq = 1'b0; alo = 1'b0; c = '0;
    case (op)
      3'b000: begin s = {1'b0, a} + {1'b0, b} + {{W{1'b0}}, ci}; c = s[W-1:0]; co = s[W]; end
      3'b001: begin c = (a >> 1) | ({{(W-1){1'b0}}, ci} << (W-1)); co = a[0]; end
      3'b010: begin c = (a << 1) | {{(W-1){1'b0}}, ci}; co = a[W-1]; end
      3'b011: c = ~a;
      3'b100: c = a & b;
      3'b101: c = a | b;
      3'b110: c = a ^ b;
      default: begin c = a ^ b; eq = (a == b); alo = (a > b); end
    endcase
    return {alo, eq, co, c};
  endfunction

  // Start an op at the next edge and wait (bounded) for wdone; optionally
  // inject a competing start pulse at edge 'inj' of the run.
  task automatic run_op(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic ci, input int inj, output int lat);
    logic [W-1:0] prev;
    logic         hold_ok, busy_ok;
    prev = wc; hold_ok = 1'b1; busy_ok = 1'b1; lat = -1;
    wop = op; wa = a; wb = b; wci = ci; wstart = 1'b1;
    @(posedge wclk); #1; wstart = 1'b0;
    for (int k = 1; k <= W + 3; k++) begin
      if (wbusy !== 1'b1 || wdone !== 1'b0) busy_ok = 1'b0;
      if (wc !== prev) hold_ok = 1'b0;
      if (k == inj) begin wstart = 1'b1; wop = 3'b011; wa = ~a; wb = ~b; end
      @(posedge wclk); #1; wstart = 1'b0;
      if (wdone === 1'b1) begin lat = k; break; end
    end
    check("busy_during_run", {31'd0, busy_ok}, 32'd1);
    check("hold_during_run", {31'd0, hold_ok}, 32'd1);
    check("busy_at_done", {31'd0, wbusy}, 32'd0);
  endtask

  task automatic check_result(input string tag, input logic [W-1:0] c, input logic co,
                              input logic eq, input logic alo, input logic z, input int lat);
    check({tag, "_latency"}, lat, W);
    check({tag, "_wc"}, {24'd0, wc}, {24'd0, c});
    check({tag, "_wco"}, {31'd0, wco}, {31'd0, co});
    check({tag, "_weqo"}, {31'd0, weqo}, {31'd0, eq});
    check({tag, "_walo"}, {31'd0, walo}, {31'd0, alo});
    check({tag, "_wz"}, {31'd0, wz}, {31'd0, z});
  endtask

  task automatic idle_cycle;
    @(posedge wclk); #1;
    check("wdone_one_cycle", {31'd0, wdone}, 32'd0);
  endtask

  vec_t vecs[12];

  initial begin
    int           lat;
    logic [W+2:0] m;
    logic [2:0]   rop;
    logic [W-1:0] ra, rb;
    logic         rci;
    logic         seen_done;

    vecs[0]  = '{3'b000, 8'h5A, 8'h3C, 1'b0, 1'b0, 8'h96, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[1]  = '{3'b000, 8'hFF, 8'h01, 1'b1, 1'b0, 8'h01, 1'b1, 1'b0, 1'b0, 1'b0};
    vecs[2]  = '{3'b110, 8'hAA, 8'hAA, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1};
    vecs[3]  = '{3'b111, 8'h80, 8'h7F, 1'b0, 1'b0, 8'hFF, 1'b0, 1'b0, 1'b1, 1'b0};
    vecs[4]  = '{3'b111, 8'h33, 8'h33, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b1};
    vecs[5]  = '{3'b010, 8'h81, 8'h00, 1'b1, 1'b0, 8'h03, 1'b1, 1'b0, 1'b0, 1'b0};
    vecs[6]  = '{3'b001, 8'h81, 8'h00, 1'b0, 1'b1, 8'h40, 1'b1, 1'b0, 1'b0, 1'b0};
    vecs[7]  = '{3'b011, 8'h0F, 8'h00, 1'b1, 1'b0, 8'hF0, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[8]  = '{3'b100, 8'hF0, 8'h3C, 1'b0, 1'b1, 8'h30, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[9]  = '{3'b101, 8'hF0, 8'h0C, 1'b0, 1'b0, 8'hFC, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[10] = '{3'b111, 8'h12, 8'h34, 1'b0, 1'b0, 8'h26, 1'b0, 1'b0, 1'b0, 1'b0};
    vecs[11] = '{3'b001, 8'h01, 8'h00, 1'b1, 1'b1, 8'h80, 1'b1, 1'b0, 1'b0, 1'b0};

    wreset = 1'b1; wstart = 1'b0; wop = '0; wa = '0; wb = '0; wci = 1'b0;
`ifdef JSERIAL_ALU_ABORT_EN
    wabort = 1'b0;
`endif
    repeat (3) @(posedge wclk);
    #1 wreset = 1'b0;
    @(posedge wclk); #1;
    check("reset_wbusy", {31'd0, wbusy}, 32'd0);
    check("reset_wdone", {31'd0, wdone}, 32'd0);
    check("reset_wc", {24'd0, wc}, 32'd0);
    check("reset_flags", {29'd0, wco, weqo, walo}, 32'd0);
    check("reset_wz", {31'd0, wz}, 32'd1);

    // Directed table; b2b entries start in the DONE cycle of the previous op.
    foreach (vecs[i]) begin
      if (!vecs[i].b2b) idle_cycle();
      run_op(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].ci, 0, lat);
      check_result($sformatf("vec%0d", i), vecs[i].c, vecs[i].co, vecs[i].eq,
                   vecs[i].alo, vecs[i].z, lat);
    end

    // Start request during RUN must be ignored.
    idle_cycle();
    run_op(3'b000, 8'h5A, 8'h3C, 1'b0, 3, lat);
    check_result("ignored_start", 8'h96, 1'b0, 1'b0, 1'b0, 1'b0, lat);
    idle_cycle();
    check("ignored_start_no_rerun", {31'd0, wbusy}, 32'd0);

    // Asynchronous reset at edge 4 of a run.
    wop = 3'b000; wa = 8'h11; wb = 8'h22; wci = 1'b0; wstart = 1'b1;
    @(posedge wclk); #1; wstart = 1'b0;
    repeat (4) @(posedge wclk);
    #2 wreset = 1'b1;
    #1;
    check("midrun_reset_wc", {24'd0, wc}, 32'd0);
    check("midrun_reset_wz", {31'd0, wz}, 32'd1);
    check("midrun_reset_wbusy", {31'd0, wbusy}, 32'd0);
    @(negedge wclk); wreset = 1'b0;
    seen_done = 1'b0;
    repeat (W + 2) begin
      @(posedge wclk); #1;
      if (wdone === 1'b1 || wbusy === 1'b1) seen_done = 1'b1;
    end
    check("midrun_reset_no_done", {31'd0, seen_done}, 32'd0);

`ifdef JSERIAL_ALU_ABORT_EN
    run_op(3'b000, 8'h5A, 8'h3C, 1'b0, 0, lat);
    check_result("pre_abort", 8'h96, 1'b0, 1'b0, 1'b0, 1'b0, lat);
    idle_cycle();
    wop = 3'b000; wa = 8'h01; wb = 8'h01; wci = 1'b0; wstart = 1'b1;
    @(posedge wclk); #1; wstart = 1'b0;
    repeat (4) @(posedge wclk);
    #1 wabort = 1'b1;
    @(posedge wclk); #1; wabort = 1'b0;
    check("abort_wbusy", {31'd0, wbusy}, 32'd0);
    seen_done = 1'b0;
    repeat (W + 2) begin
      if (wdone === 1'b1) seen_done = 1'b1;
      @(posedge wclk); #1;
    end
    check("abort_no_done", {31'd0, seen_done}, 32'd0);
    check("abort_wc_kept", {24'd0, wc}, 32'h96);
`endif

    // Random operations against the whole-word model.
    for (int n = 0; n < 40; n++) begin
      rop = 3'($urandom_range(0, 7));
      ra  = 8'($urandom);
      rb  = ($urandom_range(0, 3) == 0) ? ra : 8'($urandom);
      rci = 1'($urandom);
      if ($urandom_range(0, 1) == 0) idle_cycle();
      run_op(rop, ra, rb, rci, 0, lat);
      m = model(rop, ra, rb, rci);
      check_result($sformatf("rnd%0d", n), m[W-1:0], m[W], m[W+1], m[W+2],
                   (m[W-1:0] == '0), lat);
    end

    idle_cycle();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  // Global watchdog so the run always terminates.
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
`default_nettype wire
